// File: rtl/vram_arb_pkg.sv
// Shared types and helpers for the VRAM memory-request arbiter.
//   arb_state_t : arbiter transaction state
//   WR_SIZE_*   : encodings of the 2-bit write size field
//   slice_lo    : low bit index of channel ch inside a packed per-channel bus
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    WAIT_WR = 2'd3
  } arb_state_t;

  localparam logic [1:0] WR_SIZE_8  = 2'd0;
  localparam logic [1:0] WR_SIZE_16 = 2'd1;
  localparam logic [1:0] WR_SIZE_32 = 2'd2;

  function automatic int slice_lo(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req : request vector
//   ptr : channel with the highest priority this round
//   gnt : one-hot grant (zero when nothing requests)
//   idx : index of the granted channel
//   any : at least one request present
// Requests at or above ptr are preferred; if there are none, the lowest
// requester below ptr wins, which gives the cyclic wrap-around.
module rr_picker #(
  parameter int NUM_CH = 3,
  localparam int PTR_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] gnt,
  output logic [PTR_W-1:0]  idx,
  output logic              any
);

  logic [NUM_CH-1:0] upper;
  logic [NUM_CH-1:0] pool;
  logic              found;

  always_comb begin
    upper = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      upper[i] = req[i] && (i >= int'(ptr));
    end
    pool  = (|upper) ? upper : req;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pool[i] && !found) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = PTR_W'(i);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/mem_req_arbiter.sv
// N-channel arbiter between VRAM clients and the single SDRAM controller.
//   clk, reset_n           : controller clock, async active-low reset
//   ch_req/ch_wr/ch_addr/
//   ch_wdata/ch_wr_size    : per-channel request (packed buses)
//   ch_ack                 : one-cycle accept pulse, same cycle as the grant
//   ch_rvalid/ch_rdata     : registered read-data return to the owning channel
//   refresh_req/refresh_ack: refresh handshake, refresh beats all channels
//   mc_read/mc_write/
//   mc_refresh             : one-cycle controller strobes
//   mc_addr/mc_din/
//   mc_wr_size             : registered transaction fields
//   mc_busy/mc_rvalid/
//   mc_dout                : controller status and read data
// One transaction is outstanding at a time.
module mem_req_arbiter
  import vram_arb_pkg::*;
#(
  parameter int NUM_CH    = 3,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 32,
  parameter int FIXED_CH0 = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH*2-1:0]      ch_wr_size,
  output logic [NUM_CH-1:0]        ch_ack,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  input  logic                     refresh_req,
  output logic                     refresh_ack,
  output logic                     mc_read,
  output logic                     mc_write,
  output logic                     mc_refresh,
  output logic [ADDR_W-1:0]        mc_addr,
  output logic [DATA_W-1:0]        mc_din,
  output logic [1:0]               mc_wr_size,
  input  logic                     mc_busy,
  input  logic                     mc_rvalid,
  input  logic [DATA_W-1:0]        mc_dout
);

  localparam int PTR_W = $clog2(NUM_CH);

  arb_state_t          state_q, state_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [PTR_W-1:0]    owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [1:0]          size_q, size_d;
  logic [NUM_CH-1:0]   rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [NUM_CH-1:0]   pick_gnt;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic                fixed_win;
  logic [PTR_W-1:0]    win;
  logic [NUM_CH-1:0]   win_oh;

  rr_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req (ch_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Display fetch on channel 0 bypasses the rotation entirely.
  assign fixed_win = (FIXED_CH0 != 0) && ch_req[0];
  assign win       = fixed_win ? '0 : pick_idx;
  assign win_oh    = fixed_win ? NUM_CH'(1) : pick_gnt;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    din_d       = din_q;
    size_d      = size_q;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    ch_ack      = '0;
    refresh_ack = 1'b0;
    mc_refresh  = 1'b0;
    mc_read     = 1'b0;
    mc_write    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Acks and refresh are combinational; hold them off while in reset.
        if (reset_n && !mc_busy) begin
          if (refresh_req) begin
            mc_refresh  = 1'b1;
            refresh_ack = 1'b1;
            state_d     = WAIT_WR;
          end else if (pick_any) begin
            ch_ack  = win_oh;
            owner_d = win;
            wr_d    = ch_wr[win];
            addr_d  = ch_addr[slice_lo(int'(win), ADDR_W) +: ADDR_W];
            din_d   = ch_wdata[slice_lo(int'(win), DATA_W) +: DATA_W];
            size_d  = ch_wr_size[slice_lo(int'(win), 2) +: 2];
            if (!fixed_win) begin
              ptr_d = (pick_idx == PTR_W'(NUM_CH - 1)) ? '0 : pick_idx + PTR_W'(1);
            end
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mc_read  = !wr_q;
        mc_write = wr_q;
        state_d  = wr_q ? WAIT_WR : WAIT_RD;
      end
      WAIT_RD: begin
        // Busy is irrelevant here; only returning data ends the read.
        if (mc_rvalid) begin
          rvalid_d[owner_q] = 1'b1;
          rdata_d           = mc_dout;
          state_d           = IDLE;
        end
      end
      WAIT_WR: begin
        if (!mc_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      size_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      size_q   <= size_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ch_rvalid  = rvalid_q;
  assign ch_rdata   = rdata_q;
  assign mc_addr    = addr_q;
  assign mc_din     = din_q;
  assign mc_wr_size = size_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: two instances (pure round-robin and fixed
// channel-0 priority) run side by side, each checked every cycle against a
// transaction-level model, plus directed scenarios with constant expectations.
module tb_mem_req_arbiter;
  import vram_arb_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = 23;
  localparam int DW  = 32;
  localparam int PH_FREE = 0, PH_STROBE = 1, PH_DATA = 2, PH_CTRL = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [NCH-1:0]    req[2], wr[2], ack[2], rvalid[2];
  logic [NCH*AW-1:0] addr[2];
  logic [NCH*DW-1:0] wdata[2];
  logic [NCH*2-1:0]  wsize[2];
  logic              refresh_req[2], mc_busy[2], mc_rvalid[2];
  logic [DW-1:0]     mc_dout[2], rdata[2], mdin[2];
  logic              rack[2], mrd[2], mwr[2], mref[2];
  logic [AW-1:0]     maddr[2];
  logic [1:0]        msize[2];

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .FIXED_CH0(0)) u_rr (
    .clk(clk), .reset_n(reset_n), .ch_req(req[0]), .ch_wr(wr[0]), .ch_addr(addr[0]),
    .ch_wdata(wdata[0]), .ch_wr_size(wsize[0]), .ch_ack(ack[0]), .ch_rvalid(rvalid[0]),
    .ch_rdata(rdata[0]), .refresh_req(refresh_req[0]), .refresh_ack(rack[0]),
    .mc_read(mrd[0]), .mc_write(mwr[0]), .mc_refresh(mref[0]), .mc_addr(maddr[0]),
    .mc_din(mdin[0]), .mc_wr_size(msize[0]), .mc_busy(mc_busy[0]),
    .mc_rvalid(mc_rvalid[0]), .mc_dout(mc_dout[0]));

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .FIXED_CH0(1)) u_fx (
    .clk(clk), .reset_n(reset_n), .ch_req(req[1]), .ch_wr(wr[1]), .ch_addr(addr[1]),
    .ch_wdata(wdata[1]), .ch_wr_size(wsize[1]), .ch_ack(ack[1]), .ch_rvalid(rvalid[1]),
    .ch_rdata(rdata[1]), .refresh_req(refresh_req[1]), .refresh_ack(rack[1]),
    .mc_read(mrd[1]), .mc_write(mwr[1]), .mc_refresh(mref[1]), .mc_addr(maddr[1]),
    .mc_din(mdin[1]), .mc_wr_size(msize[1]), .mc_busy(mc_busy[1]),
    .mc_rvalid(mc_rvalid[1]), .mc_dout(mc_dout[1]));

  // Client and controller stimulus state
  bit            want[2][NCH];
  bit            t_wr[2][NCH];
  logic [AW-1:0] t_addr[2][NCH];
  logic [DW-1:0] t_data[2][NCH];
  logic [1:0]    t_size[2][NCH];
  bit            ref_want[2];
  bit            rst_want, hold_after_ack, rnd_mode, noise, force_busy, spur, use_dout_fix;
  int            lat_fix, blen_fix;
  logic [DW-1:0] dout_fix;
  int            c_busy[2], c_lat[2];
  bit            last_rd[2], last_wr[2], last_ref[2];

  // Reference model state
  int             m_ph[2], m_ptr[2], m_own[2];
  bit             m_wr[2];
  logic [AW-1:0]  m_addr[2];
  logic [DW-1:0]  m_din[2], m_rd[2];
  logic [1:0]     m_size[2];
  logic [NCH-1:0] m_rv[2];

  int n_tests = 0, n_fail = 0;
  int glog0[$], glog1[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [NCH-1:0] r, int ptr, bit fixed);
    if (fixed && r[0]) return 0;
    for (int k = 0; k < NCH; k++) if (r[(ptr + k) % NCH]) return (ptr + k) % NCH;
    return -1;
  endfunction

  task automatic apply(int d);
    bit rv;
    for (int c = 0; c < NCH; c++) begin
      if (rnd_mode) begin
        if (!want[d][c] && ($urandom % 3 == 0)) begin
          want[d][c]   = 1'b1;
          t_wr[d][c]   = 1'($urandom);
          t_addr[d][c] = AW'($urandom);
          t_data[d][c] = $urandom;
          t_size[d][c] = 2'($urandom % 3);
        end else if (want[d][c] && ($urandom % 16 == 0)) begin
          want[d][c] = 1'b0;
        end
      end
      req[d][c]               = want[d][c];
      wr[d][c]                = t_wr[d][c];
      addr[d][c*AW +: AW]     = t_addr[d][c];
      wdata[d][c*DW +: DW]    = t_data[d][c];
      wsize[d][c*2 +: 2]      = t_size[d][c];
    end
    if (rnd_mode && !ref_want[d] && ($urandom % 25 == 0)) ref_want[d] = 1'b1;
    refresh_req[d] = ref_want[d];
    if (!reset_n) begin
      c_busy[d] = 0;
      c_lat[d]  = 0;
    end else begin
      if (last_rd[d] || last_wr[d] || last_ref[d])
        c_busy[d] = (blen_fix >= 0) ? blen_fix : int'($urandom % 4);
      if (last_rd[d]) c_lat[d] = (lat_fix > 0) ? lat_fix : 2 + int'($urandom % 4);
    end
    mc_busy[d] = force_busy || (c_busy[d] > 0) || (noise && ($urandom % 5 == 0));
    if (c_busy[d] > 0) c_busy[d]--;
    rv = 1'b0;
    if (c_lat[d] > 0) begin
      c_lat[d]--;
      if (c_lat[d] == 0) rv = 1'b1;
    end
    if (spur) rv = 1'b1;
    mc_rvalid[d] = rv;
    mc_dout[d]   = (rv && use_dout_fix) ? dout_fix : $urandom;
  endtask

  task automatic eval_inst(int d);
    logic [NCH-1:0] e_ack, nrv;
    bit             e_rack, e_rd, e_wr, e_ref, nwr;
    int             w, nph, nptr, nown;
    logic [AW-1:0]  na;
    logic [DW-1:0]  nd, nrd;
    logic [1:0]     ns;
    if (!reset_n) begin
      m_ph[d] = PH_FREE; m_ptr[d] = 0; m_own[d] = 0; m_wr[d] = 0;
      m_addr[d] = '0; m_din[d] = '0; m_size[d] = '0; m_rv[d] = '0; m_rd[d] = '0;
    end
    e_ack = '0; e_rack = 0; e_rd = 0; e_wr = 0; e_ref = 0;
    nph = m_ph[d]; nptr = m_ptr[d]; nown = m_own[d]; nwr = m_wr[d];
    na = m_addr[d]; nd = m_din[d]; ns = m_size[d]; nrv = '0; nrd = m_rd[d];
    if (reset_n) begin
      if (m_ph[d] == PH_FREE) begin
        if (!mc_busy[d]) begin
          if (refresh_req[d]) begin
            e_rack = 1; e_ref = 1; nph = PH_CTRL;
          end else begin
            w = pick(req[d], m_ptr[d], d == 1);
            if (w >= 0) begin
              e_ack[w] = 1'b1;
              nown = w; nwr = wr[d][w];
              na = addr[d][w*AW +: AW]; nd = wdata[d][w*DW +: DW]; ns = wsize[d][w*2 +: 2];
              if (!(d == 1 && w == 0)) nptr = (w + 1) % NCH;
              nph = PH_STROBE;
            end
          end
        end
      end else if (m_ph[d] == PH_STROBE) begin
        e_rd = !m_wr[d]; e_wr = m_wr[d];
        nph = m_wr[d] ? PH_CTRL : PH_DATA;
      end else if (m_ph[d] == PH_DATA) begin
        if (mc_rvalid[d]) begin
          nrv[m_own[d]] = 1'b1; nrd = mc_dout[d]; nph = PH_FREE;
        end
      end else if (!mc_busy[d]) begin
        nph = PH_FREE;
      end
    end
    chk($sformatf("ch_ack%0d", d),      ack[d],    e_ack);
    chk($sformatf("refresh_ack%0d", d), rack[d],   e_rack);
    chk($sformatf("mc_read%0d", d),     mrd[d],    e_rd);
    chk($sformatf("mc_write%0d", d),    mwr[d],    e_wr);
    chk($sformatf("mc_refresh%0d", d),  mref[d],   e_ref);
    chk($sformatf("ch_rvalid%0d", d),   rvalid[d], m_rv[d]);
    chk($sformatf("ch_rdata%0d", d),    rdata[d],  m_rd[d]);
    chk($sformatf("mc_addr%0d", d),     maddr[d],  m_addr[d]);
    chk($sformatf("mc_din%0d", d),      mdin[d],   m_din[d]);
    chk($sformatf("mc_wr_size%0d", d),  msize[d],  m_size[d]);
    if (reset_n) begin
      m_ph[d] = nph; m_ptr[d] = nptr; m_own[d] = nown; m_wr[d] = nwr;
      m_addr[d] = na; m_din[d] = nd; m_size[d] = ns; m_rv[d] = nrv; m_rd[d] = nrd;
    end
    last_rd[d] = e_rd; last_wr[d] = e_wr; last_ref[d] = e_ref;
    for (int c = 0; c < NCH; c++) begin
      if (e_ack[c] && !hold_after_ack) want[d][c] = 1'b0;
      if (ack[d][c]) begin
        if (d == 0) glog0.push_back(c);
        else        glog1.push_back(c);
      end
    end
    if (e_rack) ref_want[d] = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    reset_n = !rst_want;
    for (int d = 0; d < 2; d++) apply(d);
    #1;
    for (int d = 0; d < 2; d++) eval_inst(d);
  endtask

  task automatic set_req(int c, bit w, logic [AW-1:0] a, logic [DW-1:0] dt, logic [1:0] sz);
    for (int d = 0; d < 2; d++) begin
      t_wr[d][c] = w; t_addr[d][c] = a; t_data[d][c] = dt; t_size[d][c] = sz;
      want[d][c] = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    rst_want = 1'b1; step();
    rst_want = 1'b0; step();
    glog0.delete(); glog1.delete();
  endtask

  int n;
  int exp_rr[4] = '{1, 2, 0, 1};
  int exp_fx[4] = '{1, 0, 2, 1};

  initial begin
    reset_n = 1'b0; rst_want = 1'b1; hold_after_ack = 0; rnd_mode = 0; noise = 0;
    force_busy = 0; spur = 0; use_dout_fix = 0; lat_fix = 0; blen_fix = -1; dout_fix = '0;
    for (int d = 0; d < 2; d++) begin
      ref_want[d] = 0; c_busy[d] = 0; c_lat[d] = 0; last_rd[d] = 0; last_wr[d] = 0; last_ref[d] = 0;
      for (int c = 0; c < NCH; c++) begin
        want[d][c] = 0; t_wr[d][c] = 0; t_addr[d][c] = '0; t_data[d][c] = '0; t_size[d][c] = '0;
      end
    end
    step(); step();
    rst_want = 1'b0; step(); step();

    // Single read of 0x000123, controller latency 4
    lat_fix = 4; blen_fix = 1; use_dout_fix = 1; dout_fix = 32'hDEADBEEF;
    set_req(1, 1'b0, 23'h000123, 32'h0, WR_SIZE_8);
    n = 0;
    while (!ack[0][1] && n < 20) begin step(); n++; end
    chk("rd_ack", ack[0][1], 1'b1);
    step();
    chk("rd_strobe", mrd[0], 1'b1);
    chk("rd_addr", maddr[0], 23'h000123);
    n = 1;
    while (!rvalid[0][1] && n < 20) begin step(); n++; end
    chk("rd_latency", n, 6);
    chk("rd_data", rdata[0], 32'hDEADBEEF);
    use_dout_fix = 0; lat_fix = 0; blen_fix = -1;
    repeat (3) step();

    // All channels writing continuously for 9 grants
    pulse_reset();
    hold_after_ack = 1;
    for (int c = 0; c < NCH; c++) set_req(c, 1'b1, AW'(c * 16), 32'h1000 + c, WR_SIZE_32);
    n = 0;
    while ((glog0.size() < 9 || glog1.size() < 9) && n < 300) begin step(); n++; end
    hold_after_ack = 0;
    for (int d = 0; d < 2; d++) for (int c = 0; c < NCH; c++) want[d][c] = 0;
    chk("rr_count", (glog0.size() >= 9) && (glog1.size() >= 9), 1'b1);
    for (int k = 0; k < 9 && k < glog0.size() && k < glog1.size(); k++) begin
      chk($sformatf("rr_order%0d", k), glog0[k], k % NCH);
      chk($sformatf("fx_order%0d", k), glog1[k], 0);
    end
    repeat (10) step();

    // Channel-0 priority and pointer behaviour
    pulse_reset();
    set_req(1, 1'b1, 23'h11, 32'hA1, WR_SIZE_16);
    n = 0;
    while ((want[0][1] || want[1][1]) && n < 50) begin step(); n++; end
    for (int c = 0; c < NCH; c++) set_req(c, 1'b1, AW'(c), 32'hB0 + c, WR_SIZE_32);
    n = 0;
    while ((want[0][0] || want[0][1] || want[0][2] || want[1][0] || want[1][1] || want[1][2])
           && n < 200) begin step(); n++; end
    chk("pri_count", (glog0.size() == 4) && (glog1.size() == 4), 1'b1);
    for (int k = 0; k < 4 && k < glog0.size() && k < glog1.size(); k++) begin
      chk($sformatf("pri_rr%0d", k), glog0[k], exp_rr[k]);
      chk($sformatf("pri_fx%0d", k), glog1[k], exp_fx[k]);
    end
    repeat (6) step();

    // Refresh and a channel request in the same idle cycle
    blen_fix = 3;
    for (int d = 0; d < 2; d++) ref_want[d] = 1'b1;
    set_req(1, 1'b1, 23'h22, 32'h5555AAAA, WR_SIZE_16);
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("ref_first%0d", d), rack[d], 1'b1);
      chk($sformatf("ref_noack%0d", d), ack[d], '0);
    end
    n = 0;
    while (!ack[0][1] && n < 30) begin step(); n++; end
    chk("ref_then_ch1", ack[0][1], 1'b1);
    chk("ref_gap", n, 5);
    blen_fix = -1;
    repeat (8) step();

    // Controller busy for 10 cycles with a pending 32-bit write
    force_busy = 1;
    set_req(2, 1'b1, 23'h7ABCD, 32'hCAFEF00D, WR_SIZE_32);
    repeat (10) begin
      step();
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("busy_noack%0d", d), ack[d], '0);
        chk($sformatf("busy_nostrobe%0d", d), {mrd[d], mwr[d], mref[d]}, 3'b000);
      end
    end
    force_busy = 0;
    step();
    for (int d = 0; d < 2; d++) chk($sformatf("busy_ack%0d", d), ack[d][2], 1'b1);
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy_write%0d", d), mwr[d], 1'b1);
      chk($sformatf("busy_din%0d", d), mdin[d], 32'hCAFEF00D);
      chk($sformatf("busy_size%0d", d), msize[d], WR_SIZE_32);
    end
    repeat (8) step();

    // Reset while a read is outstanding
    lat_fix = 8;
    set_req(0, 1'b0, 23'h333, 32'h0, WR_SIZE_8);
    n = 0;
    while (!ack[0][0] && n < 20) begin step(); n++; end
    step(); step();
    rst_want = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_outs%0d", d), {ack[d], rvalid[d], rack[d], mrd[d], mwr[d], mref[d]}, '0);
      chk($sformatf("rst_addr%0d", d), maddr[d], '0);
      chk($sformatf("rst_rdata%0d", d), rdata[d], '0);
    end
    step();
    rst_want = 1'b0; spur = 1;
    repeat (3) begin
      step();
      for (int d = 0; d < 2; d++) chk($sformatf("rst_no_rvalid%0d", d), rvalid[d], '0);
    end
    spur = 0; lat_fix = 0;
    repeat (4) step();

    // Randomized traffic, refresh and controller busy noise
    rnd_mode = 1; noise = 1;
    repeat (2000) step();
    rnd_mode = 0; noise = 0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Parametrised N-channel arbiter between VRAM clients (VDP pixel fetch, command engine, CPU direct access, future blitters) and the single SDRAM memory controller.
- Replaces the fixed one-client read/write/refresh wiring with round-robin arbitration, per-channel handshakes and read-data return routing.
- Sits in the clk_sdramp domain between the clients and the memory controller. Refresh always preempts new grants.

Parameters:
NUM_CH, 3, number of client channels (2..8)
ADDR_W, 23, word address width passed to the controller
DATA_W, 32, write/read data width
FIXED_CH0, 1, 1 = channel 0 has absolute priority (display fetch); 0 = pure round-robin

Ports:
clk  in  1  arbiter/controller clock
reset_n  in  1  asynchronous active-low reset
ch_req  in  NUM_CH  per-channel request, held until ch_ack
ch_wr  in  NUM_CH  1 = write, 0 = read; sampled with ch_req
ch_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  NUM_CH*DATA_W  packed write data
ch_wr_size  in  NUM_CH*2  packed write size (0 = 8b, 1 = 16b, 2 = 32b)
ch_ack  out  NUM_CH  one-cycle accept pulse
ch_rvalid  out  NUM_CH  one-cycle read-data-valid pulse
ch_rdata  out  DATA_W  shared read data, qualified by ch_rvalid
refresh_req  in  1  refresh request, held until refresh_ack
refresh_ack  out  1  one-cycle pulse when refresh is issued
mc_read  out  1  controller read strobe (one cycle)
mc_write  out  1  controller write strobe (one cycle)
mc_refresh  out  1  controller refresh strobe (one cycle)
mc_addr  out  ADDR_W  registered address
mc_din  out  DATA_W  registered write data
mc_wr_size  out  2  registered write size
mc_busy  in  1  controller busy; no strobe may be issued while high
mc_rvalid  in  1  controller read data valid
mc_dout  in  DATA_W  controller read data

Behaviour:
- Reset (async assert, sync release): all outputs 0, state IDLE, round-robin pointer 0, owner register 0.
- States: IDLE, ISSUE, WAIT_RD, WAIT_WR.
- IDLE, when mc_busy is 0:
  - If refresh_req: mc_refresh=1 and refresh_ack=1 in the same cycle; go to WAIT_WR. Refresh beats all channels.
  - Else if any ch_req: select a winner, register addr/wdata/size/wr into the mc_* registers, pulse ch_ack[winner]; next cycle ISSUE.
- Winner selection:
  - FIXED_CH0=1 and ch_req[0]: channel 0 wins.
  - Otherwise the first requesting channel at or after the pointer, cyclic.
  - After a grant, pointer = winner+1 mod NUM_CH. A channel-0 grant under FIXED_CH0 does not move the pointer.
- ISSUE: drive mc_read or mc_write for exactly one cycle. Go to WAIT_RD for a read, WAIT_WR for a write.
- WAIT_WR: wait for mc_busy=0, then IDLE. The earliest next grant is the following cycle.
- WAIT_RD:
  - On mc_rvalid: ch_rdata<=mc_dout and ch_rvalid[owner]=1 one cycle later (registered); then IDLE.
  - mc_busy is ignored until mc_rvalid arrives.
- Latency: request seen in IDLE -> ack same cycle -> strobe +1 cycle -> rdata = controller latency + 1 cycle.
- Exactly one outstanding transaction; at most one of mc_read/mc_write/mc_refresh is high in any cycle.
- ch_req dropped before ack: no transaction. ch_req held after ack: treated as a new request on the next IDLE.
- Simultaneous refresh_req and channel requests in IDLE: refresh first, channels are not acked that cycle.
- Single active requester: granted every transaction without starvation. With NUM_CH requesters continuously active and FIXED_CH0=0, each is granted once per NUM_CH grants.
- reset_n asserted mid-transaction: pending rvalid is dropped, strobes are forced low immediately, no ack is produced.

Decomposition:
- Shared package vram_arb_pkg: enum arb_state_t {IDLE, ISSUE, WAIT_RD, WAIT_WR}; constants WR_SIZE_8/16/32; function for the packed-slice index.
- One sub-module rr_picker (NUM_CH): combinational round-robin grant from a request vector and pointer, one-hot plus index output. Reused later for the CPU_IO device mux.

Test Plan:
- Single read: ch1 reads addr 0x000123, controller returns 0xDEADBEEF after 4 cycles -> ch_ack[1] in cycle 0, mc_read in cycle 1 with mc_addr 0x000123, ch_rvalid[1] with rdata 0xDEADBEEF 1 cycle after mc_rvalid.
- Round-robin fairness, NUM_CH=3, FIXED_CH0=0: all channels request writes continuously for 9 grants -> grant order 0,1,2,0,1,2,0,1,2.
- Fixed priority, FIXED_CH0=1: ch0 and ch2 both request -> ch0 granted first. ch0 drops -> ch2 granted next, pointer unchanged by the ch0 grant.
- Refresh collision: refresh_req and ch_req[1] asserted in the same IDLE cycle -> mc_refresh and refresh_ack pulse; ch1 acked only after mc_busy falls.
- Busy gating: mc_busy held high 10 cycles with ch_req[2] -> no ack and no strobe until mc_busy=0; then ack, and mc_write carries wr_size 2 and the wdata.
- Reset mid-read: reset_n low during WAIT_RD -> all outputs 0 immediately; no ch_rvalid after release even if mc_rvalid pulses.
